// File: rtl/regfile_wb.sv
// Write-back register file: two combinational read ports with same-cycle bypass,
// plus a post-reset clear sequencer that zeroes r1..rN one entry per cycle while busy is high.
module regfile_wb #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  write_enable,
    input  logic [ADDR_WIDTH-1:0] write_addr,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  read1_enable,
    input  logic [ADDR_WIDTH-1:0] read1_addr,
    output logic [DATA_WIDTH-1:0] read1_data,
    input  logic                  read2_enable,
    input  logic [ADDR_WIDTH-1:0] read2_addr,
    output logic [DATA_WIDTH-1:0] read2_data,
    output logic                  busy,
    output logic                  write_lost
);

    localparam int REG_COUNT = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] IDX_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] IDX_LAST = {ADDR_WIDTH{1'b1}};

    typedef enum logic {
        CLEAR,
        RUN
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] clear_idx_q, clear_idx_d;
    logic                  busy_q, busy_d;
    logic                  write_lost_q, write_lost_d;

    logic [DATA_WIDTH-1:0] regs_q [REG_COUNT];

    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_data;

    // Single storage write port, shared between the clear sequencer and write-back.
    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        state_d      = state_q;
        clear_idx_d  = clear_idx_q;
        busy_d       = busy_q;
        write_lost_d = write_lost_q;
        mem_we       = 1'b0;
        mem_addr     = clear_idx_q;
        mem_data     = '0;

        case (state_q)
            CLEAR: begin
                mem_we = 1'b1;
                if (write_enable) begin
                    write_lost_d = 1'b1;
                end
                if (clear_idx_q == IDX_LAST) begin
                    state_d = RUN;
                    busy_d  = 1'b0;
                end else begin
                    clear_idx_d = clear_idx_q + IDX_ONE;
                end
            end
            RUN: begin
                if (write_enable && (write_addr != '0)) begin
                    mem_we   = 1'b1;
                    mem_addr = write_addr;
                    mem_data = write_data;
                end
            end
            default: ;
        endcase

        if (reset) begin
            mem_we = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (reset) begin
            state_q      <= CLEAR;
            clear_idx_q  <= IDX_ONE;
            busy_q       <= 1'b1;
            write_lost_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            clear_idx_q  <= clear_idx_d;
            busy_q       <= busy_d;
            write_lost_q <= write_lost_d;
        end
    end

    // NOTE: the array deliberately has no reset so it maps onto RAM; the sequencer clears it instead.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            regs_q[mem_addr] <= mem_data;
        end
    end

    function automatic logic [DATA_WIDTH-1:0] read_port(
        input logic                  en,
        input logic                  is_busy,
        input logic [ADDR_WIDTH-1:0] addr,
        input logic                  wr_en,
        input logic [ADDR_WIDTH-1:0] wr_addr,
        input logic [DATA_WIDTH-1:0] wr_data,
        input logic [DATA_WIDTH-1:0] stored
    );
        logic [DATA_WIDTH-1:0] result;
        if (!en || is_busy || (addr == '0)) begin
            result = '0;
        end else if (wr_en && (wr_addr == addr)) begin
            result = wr_data;
        end else begin
            result = stored;
        end
        return result;
    endfunction

    assign read1_data = read_port(read1_enable, busy_q, read1_addr, write_enable,
                                  write_addr, write_data, regs_q[read1_addr]);
    assign read2_data = read_port(read2_enable, busy_q, read2_addr, write_enable,
                                  write_addr, write_data, regs_q[read2_addr]);

    assign busy       = busy_q;
    assign write_lost = write_lost_q;

endmodule

// File: tb/tb_regfile_wb.sv
// Bench for regfile_wb: directed vector table, clear-sequence timing sequences and a
// randomized phase against a small reference model, all read results flow through a scoreboard.
module tb_regfile_wb;

    localparam int AW = 5;
    localparam int DW = 32;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          write_enable = 1'b0;
    logic [AW-1:0] write_addr = '0;
    logic [DW-1:0] write_data = '0;
    logic          read1_enable = 1'b0;
    logic [AW-1:0] read1_addr = '0;
    logic [DW-1:0] read1_data;
    logic          read2_enable = 1'b0;
    logic [AW-1:0] read2_addr = '0;
    logic [DW-1:0] read2_data;
    logic          busy;
    logic          write_lost;

    always #5 clock = ~clock;

    regfile_wb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clock        (clock),
        .reset        (reset),
        .write_enable (write_enable),
        .write_addr   (write_addr),
        .write_data   (write_data),
        .read1_enable (read1_enable),
        .read1_addr   (read1_addr),
        .read1_data   (read1_data),
        .read2_enable (read2_enable),
        .read2_addr   (read2_addr),
        .read2_data   (read2_data),
        .busy         (busy),
        .write_lost   (write_lost)
    );

    typedef struct packed {
        logic          we;
        logic [AW-1:0] waddr;
        logic [DW-1:0] wdata;
        logic          r1en;
        logic [AW-1:0] r1addr;
        logic          r2en;
        logic [AW-1:0] r2addr;
        logic [DW-1:0] exp1;
        logic [DW-1:0] exp2;
    } vec_t;

    typedef struct packed {
        logic [DW-1:0] exp1;
        logic [DW-1:0] exp2;
    } sb_t;

    sb_t           sb_q[$];
    vec_t          vecs[10];
    logic [DW-1:0] model[32];
    int            checks = 0;
    int            errors = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle of stimulus at the falling edge, queue its expectation, compare before the rising edge.
    task automatic run_vec(input vec_t v, input string tag);
        sb_t e;
        @(negedge clock);
        write_enable = v.we;
        write_addr   = v.waddr;
        write_data   = v.wdata;
        read1_enable = v.r1en;
        read1_addr   = v.r1addr;
        read2_enable = v.r2en;
        read2_addr   = v.r2addr;
        sb_q.push_back('{exp1: v.exp1, exp2: v.exp2});
        #2;
        if (sb_q.size() == 0) begin
            check({tag, " scoreboard empty"}, 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            check({tag, " read1"}, read1_data, e.exp1);
            check({tag, " read2"}, read2_data, e.exp2);
        end
    endtask

    task automatic idle_inputs();
        write_enable = 1'b0;
        read1_enable = 1'b0;
        read2_enable = 1'b0;
    endtask

    // One edge with reset high; returns at the following falling edge with reset low.
    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        idle_inputs();
        @(negedge clock);
        reset = 1'b0;
    endtask

    // Counts rising edges until busy is observed low, bounded at 100.
    task automatic wait_not_busy(output int n);
        n = 0;
        while (busy && n < 100) begin
            @(posedge clock);
            n++;
            @(negedge clock);
        end
    endtask

    function automatic logic [DW-1:0] model_read(input logic en, input logic [AW-1:0] addr,
                                                 input logic we, input logic [AW-1:0] waddr,
                                                 input logic [DW-1:0] wdata);
        if (!en || addr == 0) return '0;
        if (we && waddr == addr) return wdata;
        return model[addr];
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n;
        vec_t v;

        vecs[0] = '{1'b1, 5'd5,  32'h1234_5678, 1'b1, 5'd6,  1'b0, 5'd5,  32'h0000_0000, 32'h0000_0000};
        vecs[1] = '{1'b1, 5'd7,  32'hCAFE_F00D, 1'b1, 5'd5,  1'b1, 5'd7,  32'h1234_5678, 32'hCAFE_F00D};
        vecs[2] = '{1'b0, 5'd7,  32'h0000_0000, 1'b1, 5'd7,  1'b0, 5'd7,  32'hCAFE_F00D, 32'h0000_0000};
        vecs[3] = '{1'b1, 5'd0,  32'hFFFF_FFFF, 1'b1, 5'd0,  1'b1, 5'd0,  32'h0000_0000, 32'h0000_0000};
        vecs[4] = '{1'b0, 5'd0,  32'hFFFF_FFFF, 1'b1, 5'd0,  1'b1, 5'd5,  32'h0000_0000, 32'h1234_5678};
        vecs[5] = '{1'b1, 5'd5,  32'hA5A5_A5A5, 1'b1, 5'd5,  1'b1, 5'd5,  32'hA5A5_A5A5, 32'hA5A5_A5A5};
        vecs[6] = '{1'b1, 5'd9,  32'h0000_0001, 1'b1, 5'd5,  1'b0, 5'd9,  32'hA5A5_A5A5, 32'h0000_0000};
        vecs[7] = '{1'b0, 5'd9,  32'h0000_0000, 1'b1, 5'd9,  1'b1, 5'd7,  32'h0000_0001, 32'hCAFE_F00D};
        vecs[8] = '{1'b1, 5'd31, 32'hFFFF_0000, 1'b1, 5'd31, 1'b1, 5'd30, 32'hFFFF_0000, 32'h0000_0000};
        vecs[9] = '{1'b0, 5'd31, 32'h0000_0000, 1'b1, 5'd31, 1'b1, 5'd1,  32'hFFFF_0000, 32'h0000_0000};

        // Reset state and clear-sequence length.
        do_reset();
        read1_enable = 1'b1; read1_addr = 5'd5;
        read2_enable = 1'b1; read2_addr = 5'd31;
        #1;
        check("reset busy", {31'd0, busy}, 32'd1);
        check("reset write_lost", {31'd0, write_lost}, 32'd0);
        check("reset read1", read1_data, 32'd0);
        check("reset read2", read2_data, 32'd0);
        idle_inputs();
        wait_not_busy(n);
        check("first clear edges", n, 32'd31);

        // Fill every register with a marker, then confirm a second reset wipes them all.
        for (int i = 1; i < 32; i++) begin
            @(negedge clock);
            write_enable = 1'b1;
            write_addr   = AW'(i);
            write_data   = 32'hDEAD_BEEF;
        end
        v = '{1'b0, 5'd0, 32'd0, 1'b1, 5'd31, 1'b1, 5'd1, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
        run_vec(v, "preload");
        do_reset();
        wait_not_busy(n);
        check("second clear edges", n, 32'd31);
        for (int i = 1; i < 32; i++) begin
            v = '{1'b0, 5'd0, 32'd0, 1'b1, AW'(i), 1'b1, AW'(32 - i), 32'd0, 32'd0};
            run_vec(v, "cleared");
        end

        // Directed table: writes, bypass, port enables, r0 handling.
        for (int i = 0; i < 10; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end
        check("table write_lost", {31'd0, write_lost}, 32'd0);

        // Randomized traffic against the reference model, starting from a cleared file.
        do_reset();
        wait_not_busy(n);
        check("random clear edges", n, 32'd31);
        for (int i = 0; i < 32; i++) model[i] = '0;
        for (int i = 0; i < 60; i++) begin
            v.we     = 1'($urandom_range(0, 1));
            v.waddr  = AW'($urandom_range(0, 7));
            v.wdata  = $urandom;
            v.r1en   = ($urandom_range(0, 3) != 0);
            v.r1addr = AW'($urandom_range(0, 7));
            v.r2en   = ($urandom_range(0, 3) != 0);
            v.r2addr = AW'($urandom_range(0, 7));
            v.exp1   = model_read(v.r1en, v.r1addr, v.we, v.waddr, v.wdata);
            v.exp2   = model_read(v.r2en, v.r2addr, v.we, v.waddr, v.wdata);
            run_vec(v, $sformatf("rand%0d", i));
            if (v.we && v.waddr != 0) model[v.waddr] = v.wdata;
        end

        // Write during CLEAR is dropped but latched in write_lost until the next reset.
        do_reset();
        repeat (4) @(posedge clock);
        @(negedge clock);
        write_enable = 1'b1; write_addr = 5'd3; write_data = 32'hAAAA_5555;
        read1_enable = 1'b1; read1_addr = 5'd3;
        #2;
        check("busy read1", read1_data, 32'd0);
        @(negedge clock);
        write_enable = 1'b0;
        check("lost set", {31'd0, write_lost}, 32'd1);
        check("lost busy", {31'd0, busy}, 32'd1);
        wait_not_busy(n);
        check("lost clear edges", n, 32'd26);
        read1_enable = 1'b1; read1_addr = 5'd3;
        #1;
        check("lost r3", read1_data, 32'd0);
        check("lost sticky", {31'd0, write_lost}, 32'd1);
        do_reset();
        check("lost reset", {31'd0, write_lost}, 32'd0);

        // Reset during CLEAR restarts the full sequence.
        repeat (10) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("restart busy", {31'd0, busy}, 32'd1);
        wait_not_busy(n);
        check("restart clear edges", n, 32'd31);

        // Write coinciding with reset is discarded silently; an r0 write in CLEAR still counts.
        @(negedge clock);
        reset = 1'b1;
        write_enable = 1'b1; write_addr = 5'd3; write_data = 32'h0000_0012;
        @(negedge clock);
        reset = 1'b0;
        write_enable = 1'b0;
        check("reset+write lost", {31'd0, write_lost}, 32'd0);
        write_enable = 1'b1; write_addr = 5'd0; write_data = 32'hFFFF_FFFF;
        @(negedge clock);
        write_enable = 1'b0;
        check("r0 write lost", {31'd0, write_lost}, 32'd1);
        wait_not_busy(n);
        check("r0 clear edges", n, 32'd30);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regfile_wb.md
Name: regfile_wb

Overview:
- General-purpose register file at the write-back end of the 5-stage MIPS pipeline.
- Consumes the registered write_enable/write_addr/write_data produced by the memory stage through the MEM/WB latch.
- Serves two combinational read ports to the decode stage.
- Storage maps to FPGA distributed/block RAM, so reset does not clear all registers in parallel. Instead a clear sequencer zeroes one register per cycle after reset, and a busy flag tells the pipeline controller to stall decode.

Parameters:
- ADDR_WIDTH, 5, register address width; REG_COUNT = 2**ADDR_WIDTH.
- DATA_WIDTH, 32, register data width.

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  synchronous, active-high
- write_enable  input  1  write-back request from MEM/WB
- write_addr  input  ADDR_WIDTH  destination register
- write_data  input  DATA_WIDTH  value to write
- read1_enable  input  1  port 1 read request
- read1_addr  input  ADDR_WIDTH  port 1 source register
- read1_data  output  DATA_WIDTH  port 1 result (combinational)
- read2_enable  input  1  port 2 read request
- read2_addr  input  ADDR_WIDTH  port 2 source register
- read2_data  output  DATA_WIDTH  port 2 result (combinational)
- busy  output  1  clear sequence in progress (registered)
- write_lost  output  1  sticky: a write arrived while busy (registered)

Behaviour:
- Reset is synchronous, active-high. Any edge with reset=1 gives:
  - state=CLEAR, clear_idx=1, busy=1, write_lost=0.
  - Any write presented on that edge is discarded and does not set write_lost.
- State CLEAR, on each edge with reset=0:
  - regs[clear_idx] <= 0.
  - If clear_idx == REG_COUNT-1: state <= RUN and busy <= 0. Otherwise clear_idx <= clear_idx+1.
  - Timing: busy drops exactly REG_COUNT-1 (31) edges after the first edge with reset=0.
- Reset asserted during CLEAR restarts the sequence at clear_idx=1.
- Register r0 is never stored; it reads as zero unconditionally.
- Writes during CLEAR are ignored (storage unchanged). A write with write_enable=1 on a non-reset edge sets write_lost=1, which stays set until reset. Writes to r0 also count for this.
- State RUN, write: on the edge, if write_enable=1 and write_addr!=0 then regs[write_addr] <= write_data. Writes to r0 are silently dropped.
- Reads are purely combinational and evaluated independently per port, in priority order:
  1. readN_enable=0 -> 0
  2. busy=1 -> 0
  3. readN_addr=0 -> 0
  4. write_enable=1 and write_addr==readN_addr -> write_data (same-cycle WB bypass)
  5. otherwise regs[readN_addr]
- Both ports may read the same address, including a bypassed one, in the same cycle.
- Register contents never change except through clear-sequence writes or RUN writes.
- The state machine has exactly two states, CLEAR and RUN. No other transitions exist.
- Outputs after reset settle: busy=1, write_lost=0, read1_data=0, read2_data=0.
- Storage has no reset term, so an array with no reset input can be inferred.

Test Plan:
- Reset 1 cycle, then idle -> busy=1 for exactly 31 edges, then 0. Reads of r1..r31 all return 0 afterwards, even if memory was preloaded with 0xDEADBEEF.
- After busy=0: write r5=0x12345678, next cycle read1 r5 -> 0x12345678. Same cycle write r7=0xCAFEF00D with read2_addr=7 -> read2_data=0xCAFEF00D (bypass). Read r7 with read2_enable=0 -> 0.
- Write r0=0xFFFFFFFF -> read r0 returns 0, both with bypass active and on the following cycle.
- During CLEAR, write r3=0xAAAA5555 -> write_lost=1 next edge. After busy=0, r3 reads 0 and write_lost remains 1. Then reset -> write_lost=0.
- Reset re-asserted after 10 clear edges -> busy stays 1 for a full 31 further edges after release.
- Reset and write_enable both high on the same edge -> write discarded and write_lost stays 0.
